// File: rtl/loader_pkg.sv
// Shared types and write codes for the program-memory boot loader.
package loader_pkg;

  typedef enum logic [1:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    DONE
  } state_e;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_WORD = 2'b01;

  // Byte offset of a word slot from the load base.
  function automatic logic [17:0] word_offset(input logic [15:0] word_idx);
    return {word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Packs received bytes little-endian into 32-bit words; word_ready_o flags
// the cycle the 4th byte arrives, with word_o already holding the full word.
module byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_i,
  input  logic        valid_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [1:0]  idx_q;
  logic [23:0] low_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      idx_q <= 2'd0;
    end else if (valid_i) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  // NOTE: the byte store has no reset; idx_q alone decides what is valid,
  // so clearing the datapath would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (valid_i) begin
      case (idx_q)
        2'd0:    low_q[7:0]   <= byte_i;
        2'd1:    low_q[15:8]  <= byte_i;
        2'd2:    low_q[23:16] <= byte_i;
        default: ;
      endcase
    end
  end

  assign word_o       = {byte_i, low_q};
  assign word_ready_o = valid_i && !clear_i && (idx_q == 2'd3);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Loads a length-prefixed byte frame into program memory as 32-bit word
// writes, holding the core in reset until the whole frame is written.
module boot_loader_ctrl
  import loader_pkg::*;
#(
  parameter int             N         = 64,
  parameter logic [N-1:0]   BASE_ADR  = '0,
  parameter int             MAX_WORDS = 256,
  parameter int             TIMEOUT   = 100000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         cpu_reset,
  output logic [1:0]   memwrite,
  output logic [N-1:0] dataadr,
  output logic [N-1:0] writedata,
  output logic [15:0]  words_loaded,
  output logic         done,
  output logic         err
);

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [16:0]     MAX_LEN  = 17'(MAX_WORDS);

  if (MAX_WORDS < 1 || MAX_WORDS > 65535 || TIMEOUT < 1 || N < 32) begin : g_bad_params
    $error("boot_loader_ctrl: MAX_WORDS must be 1..65535, TIMEOUT >= 1, N >= 32");
  end

  state_e         state_q;
  logic [7:0]     len_lo_q;
  logic [15:0]    len_q;
  logic [TW-1:0]  tmo_q;
  logic [1:0]     memwrite_q;
  logic [N-1:0]   dataadr_q;
  logic [N-1:0]   writedata_q;
  logic [15:0]    words_loaded_q;
  logic           done_q;
  logic           cpu_reset_q;
  logic           err_q;

  logic [15:0] len_w;
  logic        tmo_abort;
  logic        oversize;
  logic [31:0] asm_word;
  logic        asm_ready;

  assign len_w     = {rx_data, len_lo_q};
  assign tmo_abort = (state_q == LEN_HI || state_q == DATA) && !rx_valid && (tmo_q == TMO_LAST);
  assign oversize  = (state_q == LEN_HI) && rx_valid && ({1'b0, len_w} > MAX_LEN);

  byte_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .byte_i       (rx_data),
    .valid_i      (rx_valid && state_q == DATA),
    .clear_i      (tmo_abort || oversize),
    .word_o       (asm_word),
    .word_ready_o (asm_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= LEN_LO;
      len_lo_q       <= 8'd0;
      len_q          <= 16'd0;
      tmo_q          <= '0;
      memwrite_q     <= MW_NONE;
      dataadr_q      <= BASE_ADR;
      writedata_q    <= '0;
      words_loaded_q <= 16'd0;
      done_q         <= 1'b0;
      cpu_reset_q    <= 1'b1;
      err_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; a later assignment in this
      // block (the timeout abort) deliberately overrides the earlier default.
      memwrite_q <= MW_NONE;
      if (memwrite_q == MW_WORD) words_loaded_q <= words_loaded_q + 16'd1;

      case (state_q)
        LEN_LO: begin
          tmo_q <= '0;
          if (rx_valid) begin
            len_lo_q <= rx_data;
            state_q  <= LEN_HI;
          end
        end
        LEN_HI, DATA: begin
          if (rx_valid) begin
            tmo_q <= '0;
            if (state_q == LEN_HI) begin
              len_q <= len_w;
              if (len_w == 16'd0)  state_q <= DONE;
              else if (oversize) begin
                err_q   <= 1'b1;
                state_q <= LEN_LO;
              end else             state_q <= DATA;
            end else if (asm_ready) begin
              memwrite_q  <= MW_WORD;
              dataadr_q   <= BASE_ADR + N'(word_offset(words_loaded_q));
              writedata_q <= N'(asm_word);
              // Enter DONE now so done/cpu_reset flip the cycle after the strobe.
              if (words_loaded_q + 16'd1 == len_q) state_q <= DONE;
            end
          end else if (tmo_abort) begin
            err_q          <= 1'b1;
            words_loaded_q <= 16'd0;
            tmo_q          <= '0;
            state_q        <= LEN_LO;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        DONE: begin
          done_q      <= 1'b1;
          cpu_reset_q <= 1'b0;
        end
        default: state_q <= LEN_LO;
      endcase
    end
  end

  assign cpu_reset    = cpu_reset_q;
  assign memwrite     = memwrite_q;
  assign dataadr      = dataadr_q;
  assign writedata    = writedata_q;
  assign words_loaded = words_loaded_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed and randomized checks of the boot loader against a frame-level model.
module tb_boot_loader_ctrl;

  localparam int          N       = 64;
  localparam logic [63:0] BASE    = 64'h0;
  localparam int          MAX_W   = 256;
  localparam int          TMO     = 50;

  typedef struct {
    logic [63:0] adr;
    logic [63:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         cpu_reset;
  logic [1:0]   memwrite;
  logic [N-1:0] dataadr;
  logic [N-1:0] writedata;
  logic [15:0]  words_loaded;
  logic         done;
  logic         err;

  int checks = 0;
  int errors = 0;

  wr_t        act_q[$];
  wr_t        exp_q[$];
  logic [7:0] stream_q[$];
  logic       exp_done;
  logic       exp_err;
  int         exp_words;

  boot_loader_ctrl #(
    .N(N), .BASE_ADR(BASE), .MAX_WORDS(MAX_W), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .cpu_reset(cpu_reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .words_loaded(words_loaded), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Scoreboard capture of every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (memwrite === 2'b01) act_q.push_back('{dataadr, writedata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    act_q.delete();
  endtask

  // Byte is sampled at the next rising edge; returns in the following cycle.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cycle();
    rx_valid = 1'b0;
  endtask

  // Frame-level reference: skip oversize headers, then lay out the words.
  function automatic void run_model();
    int pos = 0;
    exp_q.delete();
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_words = 0;
    while (pos + 1 < stream_q.size() && !exp_done) begin
      int len = int'(stream_q[pos]) + 256 * int'(stream_q[pos+1]);
      pos += 2;
      if (len > MAX_W) begin
        exp_err = 1'b1;
      end else begin
        for (int w = 0; w < len; w++) begin
          longint unsigned word = 0;
          for (int k = 0; k < 4; k++)
            word += longint'(stream_q[pos + 4*w + k]) << (8 * k);
          exp_q.push_back('{BASE + 64'(4 * w), 64'(word)});
        end
        exp_words = len;
        exp_done  = 1'b1;
      end
    end
  endfunction

  task automatic compare_writes(input string tag);
    check({tag, " write count"}, 64'(act_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      check({tag, " adr"}, act_q[i].adr, exp_q[i].adr);
      check({tag, " data"}, act_q[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    // 1: reset state held with no input
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      cycle();
      check("idle reset state", {cpu_reset, memwrite, done, err, words_loaded, dataadr[31:0]},
            {1'b1, 2'b00, 1'b0, 1'b0, 16'd0, 32'd0});
    end
    check("idle writedata", writedata, 64'd0);

    // 2: two words back-to-back
    do_reset();
    send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    check("w0 strobe", 64'(memwrite), 64'd1);
    check("w0 adr", dataadr, 64'h0);
    check("w0 data", writedata, 64'h12345678);
    send(8'hEF);
    check("w0 strobe one cycle", 64'(memwrite), 64'd0);
    check("w0 count", 64'(words_loaded), 64'd1);
    send(8'hBE); send(8'hAD); send(8'hDE);
    check("w1 strobe", 64'(memwrite), 64'd1);
    check("w1 adr", dataadr, 64'h4);
    check("w1 data", writedata, 64'hDEADBEEF);
    check("cpu_reset during last strobe", 64'(cpu_reset), 64'd1);
    cycle();
    check("released after last strobe", {cpu_reset, done, err, memwrite}, {1'b0, 1'b1, 1'b0, 2'b00});
    check("two words loaded", 64'(words_loaded), 64'd2);
    check("hold adr", dataadr, 64'h4);

    // 3: zero-length frame
    do_reset();
    send(8'h00); send(8'h00);
    check("zero len not yet done", 64'(done), 64'd0);
    cycle();
    check("zero len done", {done, cpu_reset, err}, {1'b1, 1'b0, 1'b0});
    check("zero len words", 64'(words_loaded), 64'd0);
    check("zero len no strobe", 64'(act_q.size()), 64'd0);

    // 4: oversize length then a valid frame
    do_reset();
    send(8'h01); send(8'h01);
    cycle();
    check("oversize err", {err, done, cpu_reset}, {1'b1, 1'b0, 1'b1});
    send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    cycle();
    check("after oversize done", {done, err, cpu_reset}, {1'b1, 1'b1, 1'b0});
    stream_q = '{8'h01, 8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_model();
    compare_writes("oversize frame");

    // 5: timeout mid-word, then a resent frame
    do_reset();
    send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    repeat (TMO - 1) cycle();
    check("err before timeout", 64'(err), 64'd0);
    cycle();
    check("err at timeout", {err, done, cpu_reset}, {1'b1, 1'b0, 1'b1});
    check("timeout words", 64'(words_loaded), 64'd0);
    send(8'h01); send(8'h00);
    send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    cycle();
    check("resend done", {done, err, cpu_reset}, {1'b1, 1'b1, 1'b0});
    check("resend words", 64'(words_loaded), 64'd1);
    stream_q = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    run_model();
    compare_writes("resend frame");

    // 6: reset coincident with the 4th data byte (err set first to see it clear)
    do_reset();
    send(8'hFF); send(8'hFF);
    send(8'h01); send(8'h00); send(8'h01); send(8'h02); send(8'h03);
    rx_data  = 8'h04;
    rx_valid = 1'b1;
    reset    = 1'b1;
    cycle();
    rx_valid = 1'b0;
    check("reset suppresses strobe", 64'(memwrite), 64'd0);
    check("reset outputs", {cpu_reset, done, err, words_loaded}, {1'b1, 1'b0, 1'b0, 16'd0});
    check("reset adr", dataadr, 64'd0);
    check("reset data", writedata, 64'd0);
    reset = 1'b0;
    act_q.delete();

    // Randomized frames with optional oversize prefix and gaps
    for (int it = 0; it < 12; it++) begin
      int len;
      do_reset();
      stream_q.delete();
      if ($urandom_range(1, 0) == 1) begin
        int big = $urandom_range(65535, MAX_W + 1);
        stream_q.push_back(8'(big));
        stream_q.push_back(8'(big >> 8));
      end
      len = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(8, 1);
      stream_q.push_back(8'(len));
      stream_q.push_back(8'(len >> 8));
      for (int b = 0; b < 4 * len; b++) stream_q.push_back(8'($urandom));
      run_model();
      foreach (stream_q[b]) begin
        send(stream_q[b]);
        repeat ($urandom_range(2, 0)) cycle();
      end
      for (int w = 0; w < 20 && done !== 1'b1; w++) cycle();
      check("rand done", {done, cpu_reset}, {exp_done, !exp_done});
      check("rand err", 64'(err), 64'(exp_err));
      check("rand words", 64'(words_loaded), 64'(exp_words));
      compare_writes("rand frame");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
